// File: rtl/pool_pkg.sv
// Shared definitions for the row-pooling stage: window encoding, FSM states and
// the window-size decode.
package pool_pkg;

    localparam logic [1:0] WinK1 = 2'b00;
    localparam logic [1:0] WinK2 = 2'b01;
    localparam logic [1:0] WinK4 = 2'b10;

    typedef enum logic {
        StIdle,
        StAcc
    } pool_state_e;

    // Reserved encoding 2'b11 behaves as K=4.
    function automatic logic [1:0] win_log2(input logic [1:0] win);
        case (win)
            WinK1:   return 2'd0;
            WinK2:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One lane of the pooling stage: accumulator, max/sum update, average shift and mask.
// Sum/average path exists only when POOL_AVG_EN is defined.
module pool_lane #(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              upd_i,
    input  logic              avg_i,
    input  logic [1:0]        shift_i,
    input  logic              mask_i,
    input  logic [DWIDTH-1:0] din_i,
    output logic [DWIDTH-1:0] res_o
);

`ifdef POOL_AVG_EN
    localparam int AW = DWIDTH + 2;
`else
    localparam int AW = DWIDTH;
`endif

    logic signed [AW-1:0] acc_q, acc_d, row, upd_val, shifted;

    assign row = AW'($signed(din_i));

`ifdef POOL_AVG_EN
    assign upd_val = avg_i ? (acc_q + row) : ((row > acc_q) ? row : acc_q);
    assign shifted = acc_d >>> shift_i;
`else
    logic unused_cfg;
    assign unused_cfg = ^{avg_i, shift_i};
    assign upd_val    = (row > acc_q) ? row : acc_q;
    assign shifted    = acc_d;
`endif

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = row;
        end else if (upd_i) begin
            acc_d = upd_val;
        end
    end

    // Result reflects the row arriving this cycle so the top can register it directly.
    assign res_o = mask_i ? shifted[DWIDTH-1:0] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pool.sv
// Row-pooling stage: reduces K consecutive valid rows per lane by max or average.
// Average mode is compiled in only when POOL_AVG_EN is defined.
module pool
    import pool_pkg::*;
#(
    parameter int MAT_MUL_SIZE = 4,
    parameter int DWIDTH       = 8,
    parameter int MASK_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable_pool,
    input  logic [1:0]                     pool_window,
    input  logic                           pool_type,
    input  logic                           flush,
    input  logic                           in_data_available,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]          validity_mask,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_data_available,
    output logic                           done_pool
);

    localparam int RW = MAT_MUL_SIZE * DWIDTH;

    pool_state_e   state_q;
    logic [2:0]    cnt_q, cnt_d, kcnt;
    logic [1:0]    klog_q, klog, lane_shift;
    logic          avg_q, avg, type_in;
    logic [RW-1:0] out_q, lane_res;
    logic          avail_q, flush_q, done_q;
    logic          accept, fl, load, upd, emit;

`ifdef POOL_AVG_EN
    assign type_in = pool_type;
`else
    logic unused_type;
    assign unused_type = pool_type;
    assign type_in     = 1'b0;
`endif

    always_comb begin
        accept     = enable_pool & in_data_available;
        fl         = enable_pool & flush;
        // Window config is live only on the first row; afterwards the sampled copy rules.
        klog       = (state_q == StIdle) ? win_log2(pool_window) : klog_q;
        avg        = (state_q == StIdle) ? type_in : avg_q;
        kcnt       = 3'd1 << klog;
        cnt_d      = cnt_q + {2'b00, accept};
        load       = accept && (state_q == StIdle);
        upd        = accept && (state_q == StAcc);
        emit       = (accept && (cnt_d == kcnt)) || (fl && (cnt_d != 3'd0));
        lane_shift = avg ? klog : 2'd0;
    end

    for (genvar i = 0; i < MAT_MUL_SIZE; i++) begin : g_lane
        pool_lane #(
            .DWIDTH(DWIDTH)
        ) u_lane (
            .clk_i  (clk),
            .rst_ni (reset),
            .load_i (load),
            .upd_i  (upd),
            .avg_i  (avg),
            .shift_i(lane_shift),
            .mask_i (validity_mask[i]),
            .din_i  (inp_data[i*DWIDTH +: DWIDTH]),
            .res_o  (lane_res[i*DWIDTH +: DWIDTH])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            klog_q  <= 2'd0;
            avg_q   <= 1'b0;
            out_q   <= '0;
            avail_q <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            avail_q <= emit;
            flush_q <= fl;
            done_q  <= flush_q;
            if (emit) begin
                out_q   <= lane_res;
                state_q <= StIdle;
                cnt_q   <= 3'd0;
            end else if (accept) begin
                state_q <= StAcc;
                cnt_q   <= cnt_d;
            end
            if (load) begin
                klog_q <= klog;
                avg_q  <= avg;
            end
        end
    end

    assign out_data           = enable_pool ? out_q : inp_data;
    assign out_data_available = enable_pool ? avail_q : in_data_available;
    assign done_pool          = enable_pool ? done_q : 1'b1;

endmodule

// File: tb/tb_pool.sv
// Directed self-checking bench for the pooling stage.
module tb_pool;

    logic        clk;
    logic        reset;
    logic        enable_pool;
    logic [1:0]  pool_window;
    logic        pool_type;
    logic        flush;
    logic        in_data_available;
    logic [31:0] inp_data;
    logic [3:0]  validity_mask;
    logic [31:0] out_data;
    logic        out_data_available;
    logic        done_pool;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [31:0] exp_avg;

    pool #(
        .MAT_MUL_SIZE(4),
        .DWIDTH      (8),
        .MASK_WIDTH  (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable_pool       (enable_pool),
        .pool_window       (pool_window),
        .pool_type         (pool_type),
        .flush             (flush),
        .in_data_available (in_data_available),
        .inp_data          (inp_data),
        .validity_mask     (validity_mask),
        .out_data          (out_data),
        .out_data_available(out_data_available),
        .done_pool         (done_pool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    initial begin
        reset             = 1'b0;
        enable_pool       = 1'b1;
        pool_window       = 2'b01;
        pool_type         = 1'b0;
        flush             = 1'b0;
        in_data_available = 1'b0;
        inp_data          = '0;
        validity_mask     = 4'hF;
`ifdef POOL_AVG_EN
        exp_avg = mk(25, -2, 127, -128);
`else
        exp_avg = mk(41, -1, 127, -128);
`endif
        tick;
        tick;
        chk("rst_out", out_data, 32'h0);
        chk("rst_avail", 32'(out_data_available), 32'h0);
        chk("rst_done", 32'(done_pool), 32'h0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'h0);
        reset = 1'b1;
        tick;

        // K=2 max
        pool_window = 2'b01; pool_type = 1'b0;
        in_data_available = 1'b1;
        inp_data = mk(5, -3, 10, -128);
        tick;
        chk("k2max_row1_avail", 32'(out_data_available), 32'h0);
        inp_data = mk(-7, -2, 3, 127);
        tick;
        chk("k2max_avail", 32'(out_data_available), 32'h1);
        chk("k2max_out", out_data, mk(5, -2, 10, 127));
        in_data_available = 1'b0;
        tick;
        chk("k2max_pulse_end", 32'(out_data_available), 32'h0);

        // K=4 avg with a gap and a mid-window window change
        pool_window = 2'b10; pool_type = 1'b1;
        in_data_available = 1'b1;
        inp_data = mk(10, -1, 127, -128);
        tick;
        pool_window = 2'b00;
        inp_data = mk(20, -1, 127, -128);
        tick;
        in_data_available = 1'b0;
        tick;
        chk("k4avg_gap", 32'(out_data_available), 32'h0);
        in_data_available = 1'b1;
        inp_data = mk(30, -1, 127, -128);
        tick;
        chk("k4avg_row3", 32'(out_data_available), 32'h0);
        inp_data = mk(41, -2, 127, -128);
        tick;
        chk("k4avg_avail", 32'(out_data_available), 32'h1);
        chk("k4avg_out", out_data, exp_avg);
        in_data_available = 1'b0;
        tick;

        // K=4 max, three rows then flush
        pool_window = 2'b10; pool_type = 1'b0;
        in_data_available = 1'b1;
        inp_data = mk(1, -5, 0, -128);
        tick;
        inp_data = mk(9, -6, 0, -100);
        tick;
        inp_data = mk(4, -7, 0, 100);
        tick;
        in_data_available = 1'b0;
        flush = 1'b1;
        tick;
        chk("flush_avail", 32'(out_data_available), 32'h1);
        chk("flush_out", out_data, mk(9, -5, 0, 100));
        chk("flush_done_early", 32'(done_pool), 32'h0);
        flush = 1'b0;
        tick;
        chk("flush_done", 32'(done_pool), 32'h1);
        chk("flush_avail_end", 32'(out_data_available), 32'h0);
        tick;
        chk("flush_done_end", 32'(done_pool), 32'h0);

        // Flush with nothing pending
        flush = 1'b1;
        tick;
        chk("eflush_avail", 32'(out_data_available), 32'h0);
        flush = 1'b0;
        tick;
        chk("eflush_done", 32'(done_pool), 32'h1);
        chk("eflush_avail2", 32'(out_data_available), 32'h0);

        // Flush together with a row: row is included
        in_data_available = 1'b1;
        inp_data = mk(3, -4, 5, -9);
        tick;
        inp_data = mk(8, -1, 2, 2);
        flush = 1'b1;
        tick;
        chk("rowflush_avail", 32'(out_data_available), 32'h1);
        chk("rowflush_out", out_data, mk(8, -1, 5, 2));
        flush = 1'b0;
        in_data_available = 1'b0;
        tick;
        chk("rowflush_done", 32'(done_pool), 32'h1);

        // Back-to-back K=2 stream of six rows
        pool_window = 2'b01; pool_type = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_data_available = 1'b1;
            inp_data = mk(i, -i, 2 * i, 0);
            tick;
            pulses += int'(out_data_available);
            if (i % 2 == 0) begin
                chk($sformatf("b2b_avail_%0d", i), 32'(out_data_available), 32'h1);
                chk($sformatf("b2b_out_%0d", i), out_data, mk(i, -(i - 1), 2 * i, 0));
            end else begin
                chk($sformatf("b2b_avail_%0d", i), 32'(out_data_available), 32'h0);
            end
        end
        in_data_available = 1'b0;
        tick;
        pulses += int'(out_data_available);
        chk("b2b_pulses", 32'(pulses), 32'd3);

        // K=1 with masking
        pool_window = 2'b00;
        validity_mask = 4'b0101;
        in_data_available = 1'b1;
        inp_data = mk(50, 50, 50, 50);
        tick;
        chk("mask_avail", 32'(out_data_available), 32'h1);
        chk("mask_out", out_data, mk(50, 0, 50, 0));
        in_data_available = 1'b0;
        validity_mask = 4'hF;
        tick;

        // Bypass in the middle of a K=2 window: state must survive
        pool_window = 2'b01;
        in_data_available = 1'b1;
        inp_data = mk(7, 7, 7, 7);
        tick;
        enable_pool = 1'b0;
        inp_data = mk(1, 2, 3, 4);
        #1;
        chk("byp_out", out_data, mk(1, 2, 3, 4));
        chk("byp_avail", 32'(out_data_available), 32'h1);
        chk("byp_done", 32'(done_pool), 32'h1);
        tick;
        in_data_available = 1'b0;
        #1;
        chk("byp_avail_low", 32'(out_data_available), 32'h0);
        enable_pool = 1'b1;
        in_data_available = 1'b1;
        inp_data = mk(3, 100, -1, 7);
        tick;
        chk("byp_resume_avail", 32'(out_data_available), 32'h1);
        chk("byp_resume_out", out_data, mk(7, 100, 7, 7));
        in_data_available = 1'b0;
        tick;

        // Reset mid-window discards partial data
        pool_window = 2'b01;
        in_data_available = 1'b1;
        inp_data = mk(100, 100, 100, 100);
        tick;
        in_data_available = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_cnt", 32'(dut.cnt_q), 32'h0);
        chk("midrst_out", out_data, 32'h0);
        chk("midrst_avail", 32'(out_data_available), 32'h0);
        tick;
        reset = 1'b1;
        tick;
        chk("midrst_no_out", 32'(out_data_available), 32'h0);
        in_data_available = 1'b1;
        inp_data = mk(-1, 0, 0, 0);
        tick;
        chk("midrst_fresh_row1", 32'(out_data_available), 32'h0);
        inp_data = mk(-5, 0, 0, 0);
        tick;
        chk("midrst_fresh_avail", 32'(out_data_available), 32'h1);
        chk("midrst_fresh_out", out_data, mk(-1, 0, 0, 0));
        in_data_available = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pool.md
# pool

Row-pooling stage that sits directly upstream of the activation stage. It takes the `MAT_MUL_SIZE`-lane result rows of the normalization stage and reduces each group of K consecutive valid rows, per lane, to one row by max or average. The reduced row is presented on the same data/valid interface that the activation stage consumes. When disabled, the stage is a combinational pass-through.

## Interface
Parameters:
- `MAT_MUL_SIZE`, 4, lanes per row
- `DWIDTH`, 8, signed two's-complement lane width
- `MASK_WIDTH`, 4, validity mask width (one bit per lane)

Ports:
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low reset
- `enable_pool` input 1: 0 forwards inputs combinationally to outputs
- `pool_window` input 2: window K; 2'b00 = 1, 2'b01 = 2, 2'b10 = 4, 2'b11 is reserved and treated as 4
- `pool_type` input 1: 0 = max, 1 = average
- `flush` input 1: closes the current window early and emits it
- `in_data_available` input 1: `inp_data` valid this cycle
- `inp_data` input `MAT_MUL_SIZE*DWIDTH`: lane i at `[i*DWIDTH +: DWIDTH]`
- `validity_mask` input `MASK_WIDTH`: 0 forces that lane's output to zero
- `out_data` output `MAT_MUL_SIZE*DWIDTH`: pooled row
- `out_data_available` output 1: one-cycle pulse per pooled row
- `done_pool` output 1: high for the cycle after the final window of a flush is emitted

## Operation
- Bypass (`enable_pool`=0):
  - `out_data` = `inp_data`
  - `out_data_available` = `in_data_available`
  - `done_pool` = 1
  - Internal state is held, not cleared.
- State machine:
  - IDLE → ACC on an accepted row when K>1.
  - ACC → IDLE when row count reaches K or on `flush`.
  - K=1 never leaves IDLE; every accepted row is emitted.
- Window parameters:
  - `pool_window` and `pool_type` are sampled on the first row of a window and held until the window closes.
  - Changes mid-window are ignored.
- Per-lane arithmetic (signed):
  - max: signed compare; the first row loads the accumulator.
  - avg: sum held in `DWIDTH+2` bits, then arithmetic shift right by log2(K). This rounds toward −inf and cannot overflow.
- Flush:
  - A flushed partial window emits max of the rows received, or the avg sum (rows received) shifted by log2(K), i.e. zero-padded.
  - `flush` with no rows pending emits nothing but still pulses `done_pool`.
- Masking: masked lanes output zero regardless of accumulator contents.

## Timing
- Reset values:
  - `out_data` = 0
  - `out_data_available` = 0
  - `done_pool` = 0
  - state = IDLE, row counter = 0, accumulators = 0
- Latency: the output row is registered one cycle after the K-th row (or the flush cycle).
- Throughput: one input row per cycle with no backpressure. A new window may start in the same cycle the previous window's result is being registered; there is no bubble.
- Simultaneous `flush` and `in_data_available`: the row is included, then the window closes.
- `in_data_available` low inside a window: the counter holds and gaps are allowed.
- Reset asserted mid-window: partial data is discarded and no output is produced.

## Configuration
- `POOL_AVG_EN` defined:
  - avg mode supported; accumulators are `DWIDTH+2` bits.
- `POOL_AVG_EN` undefined:
  - `pool_type` is ignored and max is always used.
  - Accumulators are `DWIDTH` bits; the adder and shifter are removed.

## Structure
- Shared package `pool_pkg`:
  - window encoding constants
  - state enum (IDLE, ACC)
  - log2(K) decode function
- Sub-module `pool_lane`: one per lane. Holds the accumulator, max/avg update, shift and mask zeroing.
- The top level holds the FSM, row counter, sampled config, and the bypass muxes.

## Test plan
- K=2 max, rows lane0 = {5, −3}, then {−7, −2} → one output, lane0 = 5, lane1 = −2, one cycle after the second row.
- K=4 avg, lane0 rows 10, 20, 30, 41 → lane0 = 25. Rows −1, −1, −1, −2 → lane0 = −2 (floor).
- K=4 max, 3 rows {1, 9, 4}, then `flush` → output 9 next cycle; `done_pool` pulses the following cycle.
- Back-to-back K=2 stream of 6 rows with no gaps → exactly 3 `out_data_available` pulses, spaced 2 cycles apart.
- `validity_mask` = 4'b0101 with all inputs 50 → lanes 1 and 3 = 0, lanes 0 and 2 = 50.
- `enable_pool`=0 → `out_data` equals `inp_data` in the same cycle. Reset pulled low after 1 of 2 rows → no output and counter = 0.
